// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared types and default constants for the correlation histogram path
package corr_pkg;

    localparam int DEF_CH_W       = 2;
    localparam int DEF_INT_W      = 7;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_CENTER_BIN = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } corr_state_t;

    typedef struct packed {
        logic [DEF_CH_W-1:0]  start_ch;
        logic [DEF_CH_W-1:0]  end_ch;
        logic [DEF_INT_W-1:0] interval;
    } corr_event_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags and fall-through read data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Pointers carry one wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/corr_bin_distributer.sv
// rtl/corr_bin_distributer.sv - maps coincidence events to histogram bins and pulses the increment strobe
module corr_bin_distributer
    import corr_pkg::*;
#(
    parameter int CH_W       = DEF_CH_W,
    parameter int REF_CH     = 0,
    parameter int SIG_CH     = 3,
    parameter int INT_W      = DEF_INT_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CENTER_BIN = DEF_CENTER_BIN,
    parameter int FIFO_DEPTH = 4,
    parameter int INC_CYCLES = 6,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [CH_W-1:0]   ev_start,
    input  logic [CH_W-1:0]   ev_end,
    input  logic [INT_W-1:0]  ev_interval,
    output logic [ADDR_W-1:0] bin_addr,
    output logic              mem_inc,
    output logic              busy,
    input  logic              clear,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  drop_pair_cnt,
    output logic [CNT_W-1:0]  drop_range_cnt
);

    // Wide enough that CENTER_BIN +/- interval never wraps before the range test
    localparam int SW   = ((ADDR_W > INT_W) ? ADDR_W : INT_W) + 2;
    localparam int TMAX = (INC_CYCLES > GAP_CYCLES) ? INC_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]        INC_LOAD = TW'(INC_CYCLES - 1);
    localparam logic [TW-1:0]        GAP_LOAD = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
    localparam logic signed [SW-1:0] CENTER_S = SW'(CENTER_BIN);
    localparam logic signed [SW-1:0] ADDR_MAX = SW'((1 << ADDR_W) - 1);

    logic                     pair_fwd, pair_rev, pair_ok, range_ok;
    logic signed [SW-1:0]     interval_s, calc_addr;
    logic                     accept, fifo_push, fifo_pop;
    logic                     fifo_full, fifo_empty;
    logic [ADDR_W-1:0]        fifo_rdata;
    logic                     rdy_q;
    corr_state_t              state, state_next;
    logic [TW-1:0]            timer, timer_next;

    assign pair_fwd   = (ev_start == CH_W'(REF_CH)) && (ev_end == CH_W'(SIG_CH));
    assign pair_rev   = (ev_start == CH_W'(SIG_CH)) && (ev_end == CH_W'(REF_CH));
    assign pair_ok    = pair_fwd || pair_rev;
    assign interval_s = $signed({{(SW-INT_W){1'b0}}, ev_interval});

    // Signed bin offset from the zero-delay bin; direction set by channel order
    always_comb begin
        calc_addr = CENTER_S;
        if (ev_interval == '0)
            calc_addr = CENTER_S;
        else if (pair_fwd)
            calc_addr = CENTER_S + interval_s;
        else if (pair_rev)
            calc_addr = CENTER_S - interval_s;
    end

    assign range_ok  = !calc_addr[SW-1] && (calc_addr <= ADDR_MAX);
    assign ev_ready  = rdy_q && !fifo_full;
    assign accept    = ev_valid && ev_ready;
    assign fifo_push = accept && pair_ok && range_ok;

    // Holds ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_q <= 1'b0;
        else
            rdy_q <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (calc_addr[ADDR_W-1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pulse sequencer state and shared down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state: pop in IDLE, count out the pulse, then the optional gap
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = PULSE;
                    timer_next = INC_LOAD;
                end
            end
            PULSE: begin
                if (timer == '0) begin
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                    timer_next = GAP_LOAD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            GAP: begin
                if (timer == '0)
                    state_next = IDLE;
                else
                    timer_next = timer - TW'(1);
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Outputs of the sequencer: the pop doubles as the hit event
    always_comb begin
        fifo_pop = (state == IDLE) && !fifo_empty;
    end

    // Address is loaded on pop, one cycle ahead of the strobe, so it is settled when mem_inc rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_addr <= ADDR_W'(CENTER_BIN);
            mem_inc  <= 1'b0;
        end else begin
            if (fifo_pop)
                bin_addr <= fifo_rdata;
            mem_inc <= (state == PULSE);
        end
    end

    assign busy = !fifo_empty || (state != IDLE) || mem_inc;

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt        <= '0;
            drop_pair_cnt  <= '0;
            drop_range_cnt <= '0;
        end else if (clear) begin
            hit_cnt        <= '0;
            drop_pair_cnt  <= '0;
            drop_range_cnt <= '0;
        end else begin
            if (fifo_pop && !(&hit_cnt))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (accept && !pair_ok && !(&drop_pair_cnt))
                drop_pair_cnt <= drop_pair_cnt + CNT_W'(1);
            if (accept && pair_ok && !range_ok && !(&drop_range_cnt))
                drop_range_cnt <= drop_range_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_corr_bin_distributer.sv
// tb/tb_corr_bin_distributer.sv - directed bench with bin/pulse model for corr_bin_distributer
module tb_corr_bin_distributer;

    localparam int INC = 6;
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ev_start, ev_end;
    logic [6:0]  ev_interval;
    logic        valid_a, valid_b, clear_a, clear_b;
    logic        ready_a, ready_b, inc_a, inc_b, busy_a, busy_b;
    logic [7:0]  addr_a;
    logic [6:0]  addr_b;
    logic [3:0]  hit_a, dpair_a, drange_a;
    logic [15:0] hit_b, dpair_b, drange_b;

    always #5 clk = ~clk;

    corr_bin_distributer #(.CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ev_valid(valid_a), .ev_ready(ready_a),
        .ev_start(ev_start), .ev_end(ev_end), .ev_interval(ev_interval),
        .bin_addr(addr_a), .mem_inc(inc_a), .busy(busy_a), .clear(clear_a),
        .hit_cnt(hit_a), .drop_pair_cnt(dpair_a), .drop_range_cnt(drange_a)
    );

    corr_bin_distributer #(.ADDR_W(7), .CENTER_BIN(64)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ev_valid(valid_b), .ev_ready(ready_b),
        .ev_start(ev_start), .ev_end(ev_end), .ev_interval(ev_interval),
        .bin_addr(addr_b), .mem_inc(inc_b), .busy(busy_b), .clear(clear_b),
        .hit_cnt(hit_b), .drop_pair_cnt(dpair_b), .drop_range_cnt(drange_b)
    );

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];
    int hits_a = 0, pair_a = 0, range_a = 0;
    int hits_b = 0, pair_b = 0, range_b = 0;
    int accepts_cnt = 0;
    int first_low_at = -1;
    int prev_m[2] = '{0, 0};
    int high_run[2] = '{0, 0};
    int low_run[2] = '{0, 0};
    int first_p[2] = '{1, 1};
    int cur_addr[2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    // Expected bin for an event: -1 bad pair, -2 out of range
    function automatic int classify(input int s, input int e, input int iv, input int center, input int aw);
        int a;
        if (s == 0 && e == 3)      a = center + iv;
        else if (s == 3 && e == 0) a = center - iv;
        else return -1;
        if (a < 0 || a > (1 << aw) - 1) return -2;
        return a;
    endfunction

    task automatic send(input int inst, input int s, input int e, input int iv);
        int rdy, accepted, r;
        accepted = 0;
        @(negedge clk);
        ev_start = 2'(s); ev_end = 2'(e); ev_interval = 7'(iv);
        if (inst == 0) valid_a = 1'b1; else valid_b = 1'b1;
        for (int c = 0; c < 300; c++) begin
            rdy = (inst == 0) ? int'(ready_a) : int'(ready_b);
            if (!rdy && first_low_at < 0) first_low_at = accepts_cnt;
            @(posedge clk);
            if (rdy != 0) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (accepted != 0) begin
            accepts_cnt++;
            if (inst == 0) begin
                r = classify(s, e, iv, 128, 8);
                if (r >= 0) begin qa.push_back(r); hits_a++; end
                else if (r == -1) pair_a++;
                else range_a++;
            end else begin
                r = classify(s, e, iv, 64, 7);
                if (r >= 0) begin qb.push_back(r); hits_b++; end
                else if (r == -1) pair_b++;
                else range_b++;
            end
        end else begin
            check("accept_timeout", accepted, 1);
        end
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int done;
        done = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ((inst == 0 && !busy_a) || (inst == 1 && !busy_b)) begin
                done = 1;
                break;
            end
        end
        check("idle_timeout", done, 1);
    endtask

    // Per-cycle pulse checker: order, address, pulse length, minimum low time
    task automatic mon_step(input int inst, input int m, input int addr);
        int exp, pending;
        if (!rst_n) begin
            prev_m[inst] = 0;
            first_p[inst] = 1;
            return;
        end
        if (m != 0) begin
            if (prev_m[inst] == 0) begin
                pending = (inst == 0) ? qa.size() : qb.size();
                check("pulse_expected", int'(pending > 0), 1);
                if (pending > 0) begin
                    exp = (inst == 0) ? qa.pop_front() : qb.pop_front();
                    check("bin_addr", addr, exp);
                end
                if (first_p[inst] == 0) check("gap_low", int'(low_run[inst] >= GAP + 1), 1);
                first_p[inst] = 0;
                high_run[inst] = 1;
                cur_addr[inst] = addr;
            end else begin
                high_run[inst]++;
                check("addr_stable", addr, cur_addr[inst]);
            end
        end else begin
            if (prev_m[inst] != 0) begin
                check("pulse_len", high_run[inst], INC);
                low_run[inst] = 1;
            end else begin
                low_run[inst]++;
            end
        end
        prev_m[inst] = m;
    endtask

    always @(posedge clk) begin
        #1;
        mon_step(0, int'(inc_a), int'(addr_a));
        mon_step(1, int'(inc_b), int'(addr_b));
    end

    initial begin
        rst_n = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
        ev_start = '0; ev_end = '0; ev_interval = '0;
        repeat (3) @(negedge clk);
        check("rst_addr_a", addr_a, 128);
        check("rst_addr_b", addr_b, 64);
        check("rst_inc", inc_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_hit", hit_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", ready_a, 1);

        // Single event: latency two edges, address 133
        send(0, 0, 3, 5);
        @(negedge clk); check("lat_n0", inc_a, 0);
        @(negedge clk); check("lat_n1", inc_a, 0);
        @(negedge clk); check("lat_n2", inc_a, 1);
        check("addr_133", addr_a, 133);
        wait_idle(0);
        check("hit_one", hit_a, 1);

        send(0, 3, 0, 10);
        send(0, 0, 3, 0);
        send(0, 1, 2, 4);
        wait_idle(0);
        check("drop_pair_lit", dpair_a, 1);
        check("hit_three_lit", hit_a, 3);
        check("hit_model", hit_a, sat(hits_a, 4));

        // Range edges on the 7-bit instance
        send(1, 0, 3, 64);
        send(1, 3, 0, 64);
        send(1, 3, 0, 65);
        wait_idle(1);
        check("drop_range_lit", drange_b, 2);
        check("drop_range_model", drange_b, range_b);
        check("hit_b", hit_b, hits_b);

        // Clear then back-to-back burst of six
        @(negedge clk); clear_a = 1'b1;
        @(negedge clk); clear_a = 1'b0;
        hits_a = 0; pair_a = 0; range_a = 0;
        check("clear_hit", hit_a, 0);
        check("clear_pair", dpair_a, 0);
        accepts_cnt = 0; first_low_at = -1;
        for (int k = 0; k < 6; k++) send(0, (k % 2 == 0) ? 0 : 3, (k % 2 == 0) ? 3 : 0, 7 * k + 1);
        check("ready_fell", int'(first_low_at >= 0), 1);
        check("accepts_before_full", int'(first_low_at >= 4 && first_low_at <= 5), 1);
        wait_idle(0);
        check("burst_hits", hit_a, 6);
        check("burst_drained", qa.size(), 0);

        // Reset on pulse cycle 3 with two entries queued
        for (int k = 0; k < 3; k++) send(0, 0, 3, 30 + k);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (inc_a) begin seen = 1; break; end
            end
            check("pulse_seen", seen, 1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_inc", inc_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_ready", ready_a, 0);
        qa.delete(); qb.delete();
        hits_a = 0; pair_a = 0; range_a = 0;
        hits_b = 0; pair_b = 0; range_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", busy_a, 0);
        check("post_rst_hit", hit_a, 0);
        check("post_rst_range_b", drange_b, 0);

        // Saturation at 15, then clear coinciding with a pop
        for (int k = 0; k < 17; k++) send(0, 0, 3, k + 1);
        wait_idle(0);
        check("sat_lit", hit_a, 15);
        check("sat_model", hit_a, sat(hits_a, 4));
        send(0, 0, 3, 20);
        @(negedge clk); clear_a = 1'b1;
        @(posedge clk); #1; clear_a = 1'b0;
        hits_a = 0;
        check("clear_vs_hit", hit_a, 0);
        wait_idle(0);
        check("clear_vs_hit_after", hit_a, sat(hits_a, 4));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
